// File: rtl/generic_fifo_ctrl_sc_if.sv
`default_nettype none
// ============================================================================
// Module      : generic_fifo_ctrl_sc_if
// Description : Push/pop user-side bundle of the single-clock FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface generic_fifo_ctrl_sc_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic          clr;
    logic          we;
    logic [DW-1:0] din;
    logic          re;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    modport master (
        output clr, we, din, re,
        input  dout, dout_valid, full, almost_full, empty, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  clr, we, din, re,
        output dout, dout_valid, full, almost_full, empty, almost_empty,
               level, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/generic_fifo_ctrl_sc.sv
`default_nettype none
// ============================================================================
// Module      : generic_fifo_ctrl_sc
// Description : Single-clock FIFO controller driving a synchronous dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module generic_fifo_ctrl_sc #(
    parameter int AW       = 5,
    parameter int DW       = 16,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    generic_fifo_ctrl_sc_if.slave    fifo_if,
    output      logic                ram_wce,
    output      logic                ram_we,
    output      logic [AW-1:0]       ram_waddr,
    output      logic [DW-1:0]       ram_di,
    output      logic                ram_rce,
    output      logic [AW-1:0]       ram_raddr,
    input  wire logic [DW-1:0]       ram_do
);

    localparam logic [AW:0] c_depth    = (AW+1)'(1 << AW);
    localparam logic [AW:0] c_af_level = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] c_ae_level = (AW+1)'(AE_LEVEL);

    logic [AW-1:0] r_wp_q,         w_wp_d;
    logic [AW-1:0] r_rp_q,         w_rp_d;
    logic [AW:0]   r_level_q,      w_level_d;
    logic          r_full_q,       w_full_d;
    logic          r_empty_q,      w_empty_d;
    logic          r_afull_q,      w_afull_d;
    logic          r_aempty_q,     w_aempty_d;
    logic          r_dout_valid_q, w_dout_valid_d;
    logic          r_overflow_q,   w_overflow_d;
    logic          r_underflow_q,  w_underflow_d;

    logic w_push_ok;
    logic w_pop_ok;

    // Gating by the registered flags means a full FIFO never writes over the word being read.
    assign w_push_ok = fifo_if.we & ~r_full_q  & ~rst & ~fifo_if.clr;
    assign w_pop_ok  = fifo_if.re & ~r_empty_q & ~rst & ~fifo_if.clr;

    always_comb begin
        w_wp_d         = r_wp_q;
        w_rp_d         = r_rp_q;
        w_level_d      = r_level_q;
        w_dout_valid_d = 1'b0;
        w_overflow_d   = r_overflow_q  | (fifo_if.we & r_full_q);
        w_underflow_d  = r_underflow_q | (fifo_if.re & r_empty_q);

        if (rst) begin
            w_wp_d        = '0;
            w_rp_d        = '0;
            w_level_d     = '0;
            w_overflow_d  = 1'b0;
            w_underflow_d = 1'b0;
        end else if (fifo_if.clr) begin
            w_wp_d    = '0;
            w_rp_d    = '0;
            w_level_d = '0;
        end else begin
            if (w_push_ok) w_wp_d = r_wp_q + 1'b1;
            if (w_pop_ok)  w_rp_d = r_rp_q + 1'b1;
            w_dout_valid_d = w_pop_ok;
            if (w_push_ok && !w_pop_ok)      w_level_d = r_level_q + 1'b1;
            else if (w_pop_ok && !w_push_ok) w_level_d = r_level_q - 1'b1;
        end

        w_full_d   = (w_level_d == c_depth);
        w_empty_d  = (w_level_d == '0);
        w_afull_d  = (w_level_d >= c_af_level);
        w_aempty_d = (w_level_d <= c_ae_level);
    end

    always_ff @(posedge clk) begin
        r_wp_q         <= w_wp_d;
        r_rp_q         <= w_rp_d;
        r_level_q      <= w_level_d;
        r_full_q       <= w_full_d;
        r_empty_q      <= w_empty_d;
        r_afull_q      <= w_afull_d;
        r_aempty_q     <= w_aempty_d;
        r_dout_valid_q <= w_dout_valid_d;
        r_overflow_q   <= w_overflow_d;
        r_underflow_q  <= w_underflow_d;
    end

    assign ram_wce   = w_push_ok;
    assign ram_we    = w_push_ok;
    assign ram_waddr = r_wp_q;
    assign ram_di    = fifo_if.din;
    assign ram_rce   = w_pop_ok;
    assign ram_raddr = r_rp_q;

    // The RAM registers the read address, so its output already is the popped word.
    assign fifo_if.dout         = ram_do;
    assign fifo_if.dout_valid   = r_dout_valid_q;
    assign fifo_if.full         = r_full_q;
    assign fifo_if.almost_full  = r_afull_q;
    assign fifo_if.empty        = r_empty_q;
    assign fifo_if.almost_empty = r_aempty_q;
    assign fifo_if.level        = r_level_q;
    assign fifo_if.overflow     = r_overflow_q;
    assign fifo_if.underflow    = r_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_generic_fifo_ctrl_sc.sv
`default_nettype none
// ============================================================================
// Module      : tb_generic_fifo_ctrl_sc
// Description : Directed bench for generic_fifo_ctrl_sc with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_generic_fifo_ctrl_sc;

    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_wce, ram_we, ram_rce;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    generic_fifo_ctrl_sc_if #(.AW(AW), .DW(DW)) fif ();

    generic_fifo_ctrl_sc #(.AW(AW), .DW(DW), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_if   (fif),
        .ram_wce   (ram_wce),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_di    (ram_di),
        .ram_rce   (ram_rce),
        .ram_raddr (ram_raddr),
        .ram_do    (ram_do)
    );

    always #5 clk = ~clk;

    // Synchronous dual-port RAM with registered read.
    always_ff @(posedge clk) begin
        if (ram_wce && ram_we) mem[ram_waddr] <= ram_di;
        if (ram_rce)           ram_do <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; fif.clr = 1'b0; fif.we = 1'b0; fif.re = 1'b0; fif.din = '0;

        // Reset
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_empty", fif.empty, 1);
        chk("rst_aempty", fif.almost_empty, 1);
        chk("rst_full", fif.full, 0);
        chk("rst_afull", fif.almost_full, 0);
        chk("rst_level", fif.level, 0);
        chk("rst_dv", fif.dout_valid, 0);
        chk("rst_ovf", fif.overflow, 0);
        chk("rst_unf", fif.underflow, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_rce", ram_rce, 0);

        // Fill
        for (int i = 0; i < 32; i++) begin
            fif.we = 1'b1; fif.din = 16'(i);
            #1;
            chk("fill_ram_we", ram_we, 1);
            chk("fill_waddr", ram_waddr, i);
            tick();
            chk("fill_level", fif.level, i + 1);
            chk("fill_afull", fif.almost_full, (i + 1 >= 28) ? 1 : 0);
        end
        chk("fill_full", fif.full, 1);
        fif.din = 16'hBEEF;
        #1;
        chk("ovf_ram_we", ram_we, 0);
        tick();
        fif.we = 1'b0;
        chk("ovf_level", fif.level, 32);
        chk("ovf_flag", fif.overflow, 1);

        // Drain
        for (int i = 0; i < 32; i++) begin
            fif.re = 1'b1;
            tick();
            chk("drain_dv", fif.dout_valid, 1);
            chk("drain_dout", fif.dout, i);
            chk("drain_level", fif.level, 31 - i);
            chk("drain_aempty", fif.almost_empty, (31 - i <= 4) ? 1 : 0);
        end
        chk("drain_empty", fif.empty, 1);
        chk("drain_unf0", fif.underflow, 0);
        #1;
        chk("unf_ram_rce", ram_rce, 0);
        tick();
        fif.re = 1'b0;
        chk("unf_flag", fif.underflow, 1);
        chk("unf_dv", fif.dout_valid, 0);

        // Simultaneous push and pop while empty
        fif.we = 1'b1; fif.re = 1'b1; fif.din = 16'h0200;
        tick();
        fif.we = 1'b0; fif.re = 1'b0;
        chk("se_level", fif.level, 1);
        chk("se_dv", fif.dout_valid, 0);
        chk("se_unf", fif.underflow, 1);
        fif.re = 1'b1;
        tick();
        fif.re = 1'b0;
        chk("se_dout", fif.dout, 16'h0200);
        chk("se_dv2", fif.dout_valid, 1);
        chk("se_empty", fif.empty, 1);

        // Simultaneous push and pop at level 5
        for (int i = 0; i < 5; i++) begin
            fif.we = 1'b1; fif.din = 16'(16'h0300 + i);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            fif.we = 1'b1; fif.re = 1'b1; fif.din = 16'(16'h0305 + k);
            tick();
            chk("s5_level", fif.level, 5);
            chk("s5_dv", fif.dout_valid, 1);
            chk("s5_dout", fif.dout, 16'h0300 + k);
        end
        fif.we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("s5_tail", fif.dout, 16'h030A + k);
        end
        fif.re = 1'b0;
        chk("s5_empty", fif.empty, 1);

        // Simultaneous push and pop while full
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_ovf", fif.overflow, 0);
        for (int i = 0; i < 32; i++) begin
            fif.we = 1'b1; fif.din = 16'(16'h0400 + i);
            tick();
        end
        chk("sf_full", fif.full, 1);
        chk("sf_ovf0", fif.overflow, 0);
        fif.re = 1'b1; fif.din = 16'hBEEF;
        tick();
        fif.we = 1'b0;
        chk("sf_level", fif.level, 31);
        chk("sf_ovf", fif.overflow, 1);
        chk("sf_dout", fif.dout, 16'h0400);
        for (int i = 1; i < 32; i++) begin
            tick();
            chk("sf_drain", fif.dout, 16'h0400 + i);
        end
        fif.re = 1'b0;
        chk("sf_empty", fif.empty, 1);

        // Wrap: pops lag pushes by two cycles
        for (int c = 0; c < 102; c++) begin
            fif.we = (c < 100);
            fif.din = 16'(16'h0100 + c);
            fif.re = (c >= 2);
            tick();
            if (fif.level > 2) chk("wrap_level", fif.level, 2);
            if (c >= 2) begin
                chk("wrap_dv", fif.dout_valid, 1);
                chk("wrap_dout", fif.dout, 16'h0100 + c - 2);
            end
        end
        fif.we = 1'b0; fif.re = 1'b0;
        chk("wrap_empty", fif.empty, 1);

        // Flush at level 10 with overflow already set
        for (int i = 0; i < 10; i++) begin
            fif.we = 1'b1; fif.din = 16'(16'h0500 + i);
            tick();
        end
        fif.we = 1'b0;
        chk("fl_level10", fif.level, 10);
        fif.clr = 1'b1; fif.we = 1'b1; fif.re = 1'b1;
        #1;
        chk("fl_ram_we", ram_we, 0);
        chk("fl_ram_wce", ram_wce, 0);
        chk("fl_ram_rce", ram_rce, 0);
        tick();
        fif.clr = 1'b0; fif.we = 1'b0; fif.re = 1'b0;
        chk("fl_level", fif.level, 0);
        chk("fl_empty", fif.empty, 1);
        chk("fl_aempty", fif.almost_empty, 1);
        chk("fl_full", fif.full, 0);
        chk("fl_dv", fif.dout_valid, 0);
        chk("fl_ovf", fif.overflow, 1);
        fif.we = 1'b1; fif.din = 16'hA5A5;
        #1;
        chk("fl_waddr", ram_waddr, 0);
        tick();
        fif.we = 1'b0; fif.re = 1'b1;
        tick();
        fif.re = 1'b0;
        chk("fl_dout", fif.dout, 16'hA5A5);
        chk("fl_dv2", fif.dout_valid, 1);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("end_ovf", fif.overflow, 0);
        chk("end_unf", fif.underflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
